// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and fetch-state type for the MIPS pipeline
package mips_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP              = 32'h0000_0000;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    FETCH   = 1'b0,
    PENDING = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/pipereg_fd.sv
// rtl/pipereg_fd.sv - IF/ID pipeline register with enable and synchronous bubble clear
module pipereg_fd
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic [WORD_W-1:0] ld_instr,
  input  logic [WORD_W-1:0] ld_pcplus4,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] pcplus4,
  output logic              valid
);

  // Reset beats the enable; clear only applies when the register is enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr   <= NOP;
      pcplus4 <= '0;
      valid   <= 1'b0;
    end else if (en) begin
      if (clr) begin
        instr   <= NOP;
        pcplus4 <= '0;
        valid   <= 1'b0;
      end else begin
        instr   <= ld_instr;
        pcplus4 <= ld_pcplus4;
        valid   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/stage_fetch.sv
// rtl/stage_fetch.sv - instruction fetch stage: PC, redirect latching and IF/ID register
module stage_fetch
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  output logic [WORD_W-1:0] imem_addr,
  output logic              imem_req,
  input  logic [WORD_W-1:0] imem_rdata,
  input  logic              imem_ready,
  input  logic              stall_F,
  input  logic              stall_D,
  input  logic              flush_D,
  input  logic              pcsrc_D,
  input  logic [WORD_W-1:0] pcbranch_D,
  input  logic              jump_D,
  input  logic [WORD_W-1:0] pcjump_D,
  output logic [WORD_W-1:0] pc_F,
  output logic [WORD_W-1:0] instr_D,
  output logic [WORD_W-1:0] pcplus4_D,
  output logic              valid_D
);

  fetch_state_t      state, state_next;
  logic [WORD_W-1:0] pend_target, pend_next;
  logic [WORD_W-1:0] pc_next;
  logic [WORD_W-1:0] pc_plus4;
  logic [WORD_W-1:0] redir_target;
  logic              redirect;
  logic              fetch_done;

  assign imem_addr  = pc_F;
  assign imem_req   = !reset && !stall_F;
  assign fetch_done = imem_req && imem_ready;
  assign pc_plus4   = pc_F + 32'd4;
  assign redirect   = jump_D || pcsrc_D;

  // Jump wins over branch; targets are always word aligned.
  assign redir_target = (jump_D ? pcjump_D : pcbranch_D) & ~32'h3;

  always_comb begin
    state_next = state;
    pend_next  = pend_target;
    pc_next    = pc_F;
    if (stall_F) begin
      if (redirect) begin
        state_next = PENDING;
        pend_next  = redir_target;
      end
    end else begin
      state_next = FETCH;
      if (redirect)
        pc_next = redir_target;
      else if (state == PENDING)
        pc_next = pend_target;
      else if (fetch_done)
        pc_next = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      pend_target <= '0;
      pc_F        <= RESET_PC;
    end else begin
      state       <= state_next;
      pend_target <= pend_next;
      pc_F        <= pc_next;
    end
  end

  // Any cycle without a completed fetch inserts a bubble unless decode is stalled.
  pipereg_fd u_pipereg_fd (
    .clk        (clk),
    .reset      (reset),
    .en         (!stall_D),
    .clr        (flush_D || !fetch_done),
    .ld_instr   (imem_rdata),
    .ld_pcplus4 (pc_plus4),
    .instr      (instr_D),
    .pcplus4    (pcplus4_D),
    .valid      (valid_D)
  );

endmodule

// File: tb/tb_stage_fetch.sv
// tb/tb_stage_fetch.sv - self-checking bench for stage_fetch with a behavioural model
module tb_stage_fetch;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall_F, stall_D, flush_D;
  logic        pcsrc_D, jump_D;
  logic [31:0] pcbranch_D, pcjump_D;
  logic [31:0] pc_F, instr_D, pcplus4_D;
  logic        valid_D;

  int checks = 0;
  int errors = 0;

  // Model state: the architectural view of the stage.
  logic [31:0] m_pc, m_ptgt, m_instr, m_pp4;
  logic        m_pend, m_valid;

  always #5 clk = ~clk;

  stage_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .stall_F    (stall_F),
    .stall_D    (stall_D),
    .flush_D    (flush_D),
    .pcsrc_D    (pcsrc_D),
    .pcbranch_D (pcbranch_D),
    .jump_D     (jump_D),
    .pcjump_D   (pcjump_D),
    .pc_F       (pc_F),
    .instr_D    (instr_D),
    .pcplus4_D  (pcplus4_D),
    .valid_D    (valid_D)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    reset      = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = $urandom;
    stall_F    = 1'b0;
    stall_D    = 1'b0;
    flush_D    = 1'b0;
    pcsrc_D    = 1'b0;
    jump_D     = 1'b0;
    pcbranch_D = 32'h0;
    pcjump_D   = 32'h0;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_ptgt = 32'h0; m_pend = 1'b0;
    m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] tgt, seq;
    logic        done, redir;
    if (reset) begin
      model_reset();
      return;
    end
    done  = !stall_F && imem_ready;
    redir = jump_D || pcsrc_D;
    tgt   = jump_D ? pcjump_D : pcbranch_D;
    tgt   = {tgt[31:2], 2'b00};
    seq   = m_pc + 32'd4;
    if (!stall_D) begin
      if (flush_D || !done) begin
        m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
      end else begin
        m_instr = imem_rdata; m_pp4 = seq; m_valid = 1'b1;
      end
    end
    if (stall_F) begin
      if (redir) begin
        m_pend = 1'b1;
        m_ptgt = tgt;
      end
    end else begin
      if (redir)       m_pc = tgt;
      else if (m_pend) m_pc = m_ptgt;
      else if (done)   m_pc = seq;
      m_pend = 1'b0;
    end
  endtask

  task automatic cycle();
    #1;
    check("imem_addr", imem_addr, m_pc);
    check("imem_req", {31'b0, imem_req}, {31'b0, !reset && !stall_F});
    model_step();
    @(posedge clk);
    #1;
    check("pc_F", pc_F, m_pc);
    check("instr_D", instr_D, m_instr);
    check("pcplus4_D", pcplus4_D, m_pp4);
    check("valid_D", {31'b0, valid_D}, {31'b0, m_valid});
  endtask

  task automatic jump_to(input logic [31:0] a);
    idle();
    jump_D   = 1'b1;
    pcjump_D = a;
    cycle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    model_reset();

    // Reset overrides every other input.
    idle();
    reset = 1'b1; jump_D = 1'b1; pcjump_D = 32'h100; stall_D = 1'b0;
    cycle();
    cycle();
    check("reset_pc", pc_F, 32'h0);
    check("reset_valid", {31'b0, valid_D}, 32'h0);

    // Sequential fetch 0, 4, 8 with IF/ID one cycle behind.
    for (int i = 0; i < 3; i++) begin
      idle();
      imem_rdata = 32'h1000 + i;
      #1;
      check("seq_addr", imem_addr, 32'(4 * i));
      cycle();
      check("seq_instr", instr_D, 32'h1000 + i);
    end
    check("seq_valid", {31'b0, valid_D}, 32'h1);

    // Jump beats branch; branch target has low bits cleared.
    jump_to(32'h10);
    check("at_0x10", pc_F, 32'h10);
    idle();
    pcsrc_D = 1'b1; pcbranch_D = 32'h43; jump_D = 1'b1; pcjump_D = 32'h80;
    cycle();
    check("jump_prio", pc_F, 32'h80);
    idle();
    pcsrc_D = 1'b1; pcbranch_D = 32'h43;
    cycle();
    check("branch_align", pc_F, 32'h40);

    // Redirect during stall_F is remembered and applied on release.
    idle();
    stall_F = 1'b1; jump_D = 1'b1; pcjump_D = 32'h200;
    cycle();
    check("stall_hold1", pc_F, 32'h40);
    idle();
    stall_F = 1'b1;
    cycle();
    check("stall_hold2", pc_F, 32'h40);
    check("stall_bubble", {31'b0, valid_D}, 32'h0);
    idle();
    cycle();
    check("pend_apply", pc_F, 32'h200);

    // Memory wait holds PC and inserts bubbles.
    jump_to(32'h8);
    for (int i = 0; i < 2; i++) begin
      idle();
      imem_ready = 1'b0;
      cycle();
      check("wait_pc", pc_F, 32'h8);
      check("wait_valid", {31'b0, valid_D}, 32'h0);
    end
    idle();
    imem_rdata = 32'hDEAD_BEEF;
    cycle();
    check("wait_instr", instr_D, 32'hDEAD_BEEF);
    check("wait_pp4", pcplus4_D, 32'hC);

    // stall_D outranks flush_D; flush alone inserts a bubble.
    idle();
    imem_rdata = 32'h1234_5678;
    cycle();
    idle();
    stall_D = 1'b1; flush_D = 1'b1;
    cycle();
    check("hold_instr", instr_D, 32'h1234_5678);
    idle();
    flush_D = 1'b1;
    cycle();
    check("flush_instr", instr_D, 32'h0);
    check("flush_valid", {31'b0, valid_D}, 32'h0);

    // PC wraps modulo 2^32.
    jump_to(32'hFFFF_FFFC);
    idle();
    cycle();
    check("wrap_pc", pc_F, 32'h0);
    check("wrap_pp4", pcplus4_D, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      idle();
      reset      = ($urandom_range(0, 99) < 2);
      imem_ready = ($urandom_range(0, 3) != 0);
      stall_F    = ($urandom_range(0, 4) == 0);
      stall_D    = ($urandom_range(0, 6) == 0);
      flush_D    = ($urandom_range(0, 9) == 0);
      pcsrc_D    = ($urandom_range(0, 9) == 0);
      jump_D     = ($urandom_range(0, 11) == 0);
      pcbranch_D = $urandom;
      pcjump_D   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 | 32'($urandom_range(0, 7)) : $urandom;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_fetch.md
STAGE_FETCH -- requirements
Module: stage_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Port clk, input, 1 bit, is the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1 bit, is the synchronous, active-high reset.
REQ-004 Port imem_addr, output, 32 bits, is the instruction memory address and always equals pc_F.
REQ-005 Port imem_req, output, 1 bit, is the fetch request and equals !reset && !stall_F.
REQ-006 Port imem_rdata, input, 32 bits, is the instruction word, valid in the same cycle when imem_ready=1.
REQ-007 Port imem_ready, input, 1 bit, is the memory completion flag for the current request.
REQ-008 Port stall_F, input, 1 bit, is the hazard-unit hold for the PC.
REQ-009 Port stall_D, input, 1 bit, is the hazard-unit hold for the IF/ID register.
REQ-010 Port flush_D, input, 1 bit, is the hazard-unit bubble insert into IF/ID.
REQ-011 Port pcsrc_D and pcbranch_D, inputs, 1 bit and 32 bits, are the taken-branch flag and branch target from decode.
REQ-012 Port jump_D and pcjump_D, inputs, 1 bit and 32 bits, are the jump flag and jump target from decode.
REQ-013 Port pc_F, output, 32 bits, is the current fetch PC.
REQ-014 Ports instr_D, pcplus4_D and valid_D, outputs, 32, 32 and 1 bits, are the IF/ID register contents feeding stage_decode.

Function
REQ-015 A fetch completes in a cycle with imem_req=1 and imem_ready=1.
REQ-016 Redirect target selection: jump_D=1 gives pcjump_D; otherwise pcsrc_D=1 gives pcbranch_D; jump has priority.
REQ-017 Redirect targets have bits [1:0] forced to 0, so pc_F[1:0] is always 2'b00.
REQ-018 With stall_F=0 and a redirect input asserted, pc_F loads the target next cycle, abandoning any incomplete fetch, and the pending redirect is cleared.
REQ-019 With stall_F=0, no redirect input, and pending redirect valid, pc_F loads the pending target, which is then cleared.
REQ-020 With stall_F=0, no redirect of either kind, and fetch complete, pc_F loads pc_F+4, computed modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
REQ-021 With stall_F=0, no redirect, and imem_ready=0, pc_F holds.
REQ-022 With stall_F=1, pc_F holds; a redirect input asserted that cycle is latched as pending (last one wins).
REQ-023 The state machine has two states: FETCH (no pending redirect) and PENDING (pending redirect valid).
REQ-024 FETCH goes to PENDING on a redirect input while stall_F=1.
REQ-025 PENDING goes to FETCH on the first cycle with stall_F=0.
REQ-026 IF/ID update priority is stall_D > flush_D > load > bubble.
REQ-027 With stall_D=1, instr_D, pcplus4_D and valid_D hold.
REQ-028 With stall_D=0 and flush_D=1, IF/ID loads a bubble: instr_D=NOP (32'h0), pcplus4_D=0, valid_D=0.
REQ-029 With stall_D=0, flush_D=0 and a fetch complete, IF/ID loads instr_D=imem_rdata, pcplus4_D=pc_F+4 and valid_D=1, with latency of 1 cycle from completion.
REQ-030 With stall_D=0, flush_D=0 and no fetch complete (stall_F=1 or imem_ready=0), IF/ID loads a bubble.
REQ-031 Redirects do not auto-flush IF/ID; flushing is solely by flush_D.

Reset
REQ-032 While reset=1 at a clock edge, pc_F=RESET_PC, instr_D=NOP, pcplus4_D=0, valid_D=0 and state=FETCH, overriding every other input.
REQ-033 Reset asserted mid-operation discards any pending redirect and incomplete fetch.
REQ-034 The first request after reset deasserts is at RESET_PC.

Structure
REQ-035 Package mips_pkg holds the NOP constant, the default RESET_PC, the word width constant and the fetch-state enum {FETCH, PENDING}.
REQ-036 The IF/ID register is one sub-module, pipereg_fd, with enable (!stall_D), synchronous clear, and data inputs.

Verification
REQ-037 Reset, then imem_ready=1 for 3 cycles -> imem_addr 0, 4, 8; instr_D follows with a 1-cycle lag; valid_D=1.
REQ-038 pc_F=0x10, pcsrc_D=1, pcbranch_D=0x43, jump_D=1, pcjump_D=0x80 -> next pc_F=0x80, and bits [1:0] are cleared on a branch-only retry to 0x40.
REQ-039 stall_F=1 for 2 cycles with jump_D=1 (target 0x200) in the first -> pc_F held, bubbles in D, then pc_F=0x200 after release.
REQ-040 imem_ready=0 for 2 cycles at pc 0x8 -> pc_F holds 0x8, valid_D=0 twice, then loads imem_rdata with pcplus4_D=0xC.
REQ-041 stall_D=1 and flush_D=1 together -> IF/ID holds; flush_D alone -> instr_D=0, valid_D=0.
REQ-042 pc_F=0xFFFF_FFFC, fetch completes -> pc_F=0, pcplus4_D=0.
